// File: rtl/calc_display_ctrl.sv
// Display stage: rebuilds the 8-digit number serialised by the calculator core and scans it onto
// 8 multiplexed 7-segment digits. Optional macro LEADING_ZERO_BLANK_EN suppresses leading zeros.
module calc_display_ctrl #(
  parameter int DWELL_CYCLES = 12500,
  parameter bit SEG_ACT_LOW  = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [7:0] an,
  output logic [7:0] dec_ddp,
  output logic       upd,
  output logic       err
);

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_TERM = DW'(DWELL_CYCLES - 1);
  localparam logic [7:0] ALL_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;

  logic [DW-1:0] dwell_reg;
  logic [2:0]    scan_reg;
  logic [3:0]    pos_q;
  logic [3:0]    stage_reg [8];
  logic [3:0]    disp_reg  [8];
  logic          err_reg;
  logic          upd_reg;
  logic [7:0]    an_reg;
  logic [7:0]    seg_reg;

  logic       err_now;
  logic       capture_en;
  logic       wr_en;
  logic       commit;
  logic       abort;
  logic [3:0] pos_m1;
  logic [2:0] wr_idx;
  logic [7:0] nz;
  logic [7:0] show;
  logic [7:0] onehot_next;
  logic [7:0] seg_next;

  // Active-high {g,f,e,d,c,b,a}; codes 10-15 blank.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0: seg7 = 7'h3F;
      4'd1: seg7 = 7'h06;
      4'd2: seg7 = 7'h5B;
      4'd3: seg7 = 7'h4F;
      4'd4: seg7 = 7'h66;
      4'd5: seg7 = 7'h6D;
      4'd6: seg7 = 7'h7D;
      4'd7: seg7 = 7'h07;
      4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // "ErrOr" right-justified: E on digit 4 down to r on digit 0.
  function automatic logic [6:0] err_glyph(input logic [2:0] d);
    case (d)
      3'd0: err_glyph = 7'h50;
      3'd1: err_glyph = 7'h3F;
      3'd2: err_glyph = 7'h50;
      3'd3: err_glyph = 7'h50;
      3'd4: err_glyph = 7'h79;
      default: err_glyph = 7'h00;
    endcase
  endfunction

  assign err_now    = (status == 2'b00);
  assign capture_en = !err_reg && !err_now;
  assign pos_m1     = pos - 4'd1;
  assign wr_idx     = pos_m1[2:0];
  assign wr_en      = capture_en && (status == 2'b11) && (pos != pos_q) &&
                      (pos >= 4'd1) && (pos <= 4'd8);
  assign commit     = capture_en && (pos_q == 4'd8) && (pos == 4'd0);
  assign abort      = capture_en && (pos_q >= 4'd1) && (pos_q <= 4'd7) && (pos == 4'd0);

  // A digit is shown if it or any more-significant digit is non-zero; digit 0 always shows.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      assign nz[gi] = (disp_reg[gi] != 4'd0);
`ifdef LEADING_ZERO_BLANK_EN
      if (gi == 0) begin : g_lsd
        assign show[gi] = 1'b1;
      end else begin : g_upper
        assign show[gi] = |(nz >> gi);
      end
`else
      assign show[gi] = 1'b1;
`endif
    end
  endgenerate

  always_comb begin
    onehot_next = 8'd1 << scan_reg;
    seg_next    = 8'h00;
    if (err_reg)
      seg_next = {1'b0, err_glyph(scan_reg)};
    else if (show[scan_reg])
      seg_next = {1'b0, seg7(disp_reg[scan_reg])};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        stage_reg[i] <= 4'd0;
        disp_reg[i]  <= 4'd0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (commit || abort)
          stage_reg[i] <= 4'd0;
        else if (wr_en && (wr_idx == 3'(i)))
          stage_reg[i] <= data;
        if (commit)
          disp_reg[i] <= stage_reg[i];
      end
    end
  end

  // Scan: an and segments both register from scan_reg; the wrap clock is blanked.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dwell_reg <= '0;
      scan_reg  <= 3'd0;
      pos_q     <= 4'd0;
      err_reg   <= 1'b0;
      upd_reg   <= 1'b0;
      an_reg    <= ALL_OFF;
      seg_reg   <= ALL_OFF;
    end else begin
      pos_q   <= pos;
      upd_reg <= commit;
      if (err_now)
        err_reg <= 1'b1;
      if (dwell_reg == DWELL_TERM) begin
        dwell_reg <= '0;
        scan_reg  <= scan_reg + 3'd1;
        an_reg    <= ALL_OFF;
        seg_reg   <= ALL_OFF;
      end else begin
        dwell_reg <= dwell_reg + 1'b1;
        an_reg    <= SEG_ACT_LOW ? ~onehot_next : onehot_next;
        seg_reg   <= SEG_ACT_LOW ? ~seg_next : seg_next;
      end
    end
  end

  assign an      = an_reg;
  assign dec_ddp = seg_reg;
  assign upd     = upd_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_calc_display_ctrl.sv
// Bench for calc_display_ctrl: table vectors, scan timing, error/abort sequences and
// randomized frames checked against a frame-level model of the display contents.
module tb_calc_display_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] status = 2'b10;
  logic [3:0] data = 4'd0;
  logic [3:0] pos = 4'd0;
  logic [7:0] an, dec_ddp;
  logic       upd, err;

  int checks = 0;
  int errors = 0;

  calc_display_ctrl #(.DWELL_CYCLES(4), .SEG_ACT_LOW(1'b1)) dut (
    .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
    .an(an), .dec_ddp(dec_ddp), .upd(upd), .err(err)
  );

  always #5 clock = ~clock;

  // Frame-level model of the display
  int   m_stage [8];
  int   m_disp [8];
  int   m_posq;
  logic m_err;
  logic m_upd;
  logic [7:0] seg_lut [16];

  typedef struct {
    logic [1:0] st;
    logic [3:0] p;
    logic [3:0] d;
    logic       eu;
    logic       ee;
  } vec_t;
  vec_t vt [24];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_stage[i] = 0;
      m_disp[i]  = 0;
    end
    m_posq = 0;
    m_err  = 1'b0;
    m_upd  = 1'b0;
  endtask

  task automatic model_step(input int st, input int p, input int d);
    logic ok;
    ok = !m_err && (st != 0);
    m_upd = 1'b0;
    if (ok && st == 3 && p != m_posq && p >= 1 && p <= 8)
      m_stage[p-1] = d;
    if (ok && m_posq == 8 && p == 0) begin
      for (int i = 0; i < 8; i++) m_disp[i] = m_stage[i];
      m_upd = 1'b1;
    end else if (ok && m_posq >= 1 && m_posq <= 7 && p == 0) begin
      for (int i = 0; i < 8; i++) m_stage[i] = 0;
    end
    if (st == 0) m_err = 1'b1;
    m_posq = p;
  endtask

  function automatic logic [7:0] exp_seg(input int k);
    logic lead;
    int   v;
    if (m_err) begin
      case (k)
        0, 2, 3: return 8'hAF;
        1:       return 8'hC0;
        4:       return 8'h86;
        default: return 8'hFF;
      endcase
    end
    v = m_disp[k];
    lead = 1'b1;
    for (int j = k; j < 8; j++) if (m_disp[j] != 0) lead = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && lead) return 8'hFF;
`endif
    return seg_lut[v];
  endfunction

  task automatic tick(input logic [1:0] st, input logic [3:0] p, input logic [3:0] d);
    @(negedge clock);
    status = st;
    pos    = p;
    data   = d;
    @(posedge clock);
    model_step(int'(st), int'(p), int'(d));
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset  = 1'b1;
    status = 2'b10;
    pos    = 4'd0;
    data   = 4'd0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_an", an, 8'hFF);
    chk("reset_dec", dec_ddp, 8'hFF);
    chk("reset_err", {7'd0, err}, 8'd0);
    chk("reset_upd", {7'd0, upd}, 8'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Watch one full scan and compare each digit the first time it is lit
  task automatic check_display(input logic [7:0] exp [8], input string name);
    logic [7:0] seen;
    int k;
    repeat (2) tick(2'b10, 4'd0, 4'd0);
    seen = 8'h00;
    for (int c = 0; c < 40 && seen != 8'hFF; c++) begin
      tick(2'b10, 4'd0, 4'd0);
      if (an != 8'hFF) begin
        k = -1;
        for (int i = 0; i < 8; i++) if (an == ~(8'd1 << i)) k = i;
        if (k < 0) begin
          checks++;
          errors++;
          $display("FAIL %s_an_onehot: got %h expected one-hot low", name, an);
        end else if (!seen[k]) begin
          seen[k] = 1'b1;
          chk($sformatf("%s_digit%0d", name, k), dec_ddp, exp[k]);
        end
      end
    end
    chk({name, "_all_digits_seen"}, seen, 8'hFF);
  endtask

  task automatic check_model_display(input string name);
    logic [7:0] e [8];
    for (int i = 0; i < 8; i++) e[i] = exp_seg(i);
    check_display(e, name);
  endtask

  initial begin
    logic [7:0] e [8];
    logic [7:0] lz;
    int nframes, len, hold, idle;

    seg_lut[0] = 8'hC0; seg_lut[1] = 8'hF9; seg_lut[2] = 8'hA4; seg_lut[3] = 8'hB0;
    seg_lut[4] = 8'h99; seg_lut[5] = 8'h92; seg_lut[6] = 8'h82; seg_lut[7] = 8'hF8;
    seg_lut[8] = 8'h80; seg_lut[9] = 8'h90;
    for (int i = 10; i < 16; i++) seg_lut[i] = 8'hFF;
`ifdef LEADING_ZERO_BLANK_EN
    lz = 8'hFF;
`else
    lz = 8'hC0;
`endif

    // Frame "42", aborted frame, then error mid-frame
    vt[0]  = '{2'd3, 4'd1, 4'd2, 1'b0, 1'b0};
    vt[1]  = '{2'd3, 4'd2, 4'd4, 1'b0, 1'b0};
    vt[2]  = '{2'd3, 4'd3, 4'd0, 1'b0, 1'b0};
    vt[3]  = '{2'd3, 4'd4, 4'd0, 1'b0, 1'b0};
    vt[4]  = '{2'd3, 4'd5, 4'd0, 1'b0, 1'b0};
    vt[5]  = '{2'd3, 4'd6, 4'd0, 1'b0, 1'b0};
    vt[6]  = '{2'd3, 4'd7, 4'd0, 1'b0, 1'b0};
    vt[7]  = '{2'd3, 4'd8, 4'd0, 1'b0, 1'b0};
    vt[8]  = '{2'd2, 4'd0, 4'd0, 1'b1, 1'b0};
    vt[9]  = '{2'd2, 4'd0, 4'd0, 1'b0, 1'b0};
    vt[10] = '{2'd3, 4'd1, 4'd5, 1'b0, 1'b0};
    vt[11] = '{2'd3, 4'd2, 4'd5, 1'b0, 1'b0};
    vt[12] = '{2'd3, 4'd3, 4'd5, 1'b0, 1'b0};
    vt[13] = '{2'd2, 4'd0, 4'd0, 1'b0, 1'b0};
    vt[14] = '{2'd3, 4'd1, 4'd7, 1'b0, 1'b0};
    vt[15] = '{2'd0, 4'd2, 4'd7, 1'b0, 1'b1};
    vt[16] = '{2'd3, 4'd3, 4'd7, 1'b0, 1'b1};
    vt[17] = '{2'd3, 4'd4, 4'd7, 1'b0, 1'b1};
    vt[18] = '{2'd3, 4'd5, 4'd7, 1'b0, 1'b1};
    vt[19] = '{2'd3, 4'd6, 4'd7, 1'b0, 1'b1};
    vt[20] = '{2'd3, 4'd7, 4'd7, 1'b0, 1'b1};
    vt[21] = '{2'd3, 4'd8, 4'd7, 1'b0, 1'b1};
    vt[22] = '{2'd2, 4'd0, 4'd0, 1'b0, 1'b1};
    vt[23] = '{2'd2, 4'd0, 4'd0, 1'b0, 1'b1};

    do_reset();

    // Scan timing: 3 lit clocks + 1 blank per digit, FE..7F then wrap
    for (int c = 1; c <= 36; c++) begin
      int kk;
      logic [7:0] exp_an;
      @(posedge clock);
      #1;
      kk = (c - 1) % 32;
      exp_an = ((kk % 4) == 3) ? 8'hFF : ~(8'd1 << (kk / 4));
      chk($sformatf("scan_c%0d", c), an, exp_an);
    end

    for (int i = 0; i < 24; i++) begin
      tick(vt[i].st, vt[i].p, vt[i].d);
      chk($sformatf("vec%0d_upd", i), {7'd0, upd}, {7'd0, vt[i].eu});
      chk($sformatf("vec%0d_err", i), {7'd0, err}, {7'd0, vt[i].ee});
      if (i == 9 || i == 13) begin
        e[0] = 8'hA4; e[1] = 8'h99;
        for (int j = 2; j < 8; j++) e[j] = lz;
        check_display(e, (i == 9) ? "frame42" : "after_abort");
      end
    end
    e[0] = 8'hAF; e[1] = 8'hC0; e[2] = 8'hAF; e[3] = 8'hAF; e[4] = 8'h86;
    e[5] = 8'hFF; e[6] = 8'hFF; e[7] = 8'hFF;
    check_display(e, "error_pattern");
    chk("err_sticky", {7'd0, err}, 8'd1);

    do_reset();
    e[0] = 8'hC0;
    for (int j = 1; j < 8; j++) e[j] = lz;
    check_display(e, "post_reset_zero");

    // Randomized frames: full or aborted, held positions, idle gaps, pos>8 noise
    for (nframes = 0; nframes < 30; nframes++) begin
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
      for (int p = 1; p <= len; p++) begin
        hold = $urandom_range(1, 2);
        for (int h = 0; h < hold; h++) begin
          tick(2'b11, 4'(p), 4'($urandom_range(0, 15)));
          chk("rnd_upd", {7'd0, upd}, {7'd0, m_upd});
          chk("rnd_err", {7'd0, err}, {7'd0, m_err});
        end
      end
      tick(2'b10, 4'd0, 4'd0);
      chk("rnd_commit_upd", {7'd0, upd}, {7'd0, m_upd});
      idle = $urandom_range(0, 2);
      for (int j = 0; j < idle; j++) begin
        tick(2'b01, 4'($urandom_range(9, 15)), 4'($urandom_range(0, 15)));
        chk("rnd_idle_upd", {7'd0, upd}, {7'd0, m_upd});
      end
      tick(2'b10, 4'd0, 4'd0);
      if (nframes % 5 == 4)
        check_model_display($sformatf("rnd_frame%0d", nframes));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
